// File: rtl/dom_pkg.sv
// Shared definitions for the DOM share generator: share count, LFSR constants,
// FSM state encoding, the registered output bundle and single-step LFSR helpers.
// No logic lives here; the top and the LFSR sub-module import it.
package dom_pkg;

    // Number of Boolean shares per operand and of refreshing bits.
    localparam int SHARES = 3;

    // Galois tap mask for x^32 + x^22 + x^2 + x + 1 in right-shift form.
    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

    // LFSR advance per clock while seeded.
    localparam int LFSR_STEPS = 8;

    // Reset value, and the value used when software supplies an all-zero seed.
    // An all-zero Galois LFSR would stay locked at zero forever.
    localparam logic [31:0] LFSR_NONZERO = 32'h0000_0001;

    typedef enum logic [1:0] {
        ST_UNSEEDED = 2'd0,
        ST_WARMUP   = 2'd1,
        ST_RUN      = 2'd2
    } dom_state_e;

    // Registered output bundle presented to the downstream DOM AND stage.
    typedef struct packed {
        logic [SHARES-1:0] a_sh;
        logic [SHARES-1:0] b_sh;
        logic [SHARES-1:0] refreshing;
    } share_dat_t;

    // One Galois step: shift right, fold the tap mask in when a one falls out.
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_POLY : 32'h0000_0000);
    endfunction

    // Seed sanitiser: zero is the one state the LFSR can never leave.
    function automatic logic [31:0] lfsr_seed_fix(input logic [31:0] s);
        return (s == 32'h0000_0000) ? LFSR_NONZERO : s;
    endfunction

endpackage

// File: rtl/dom_lfsr32.sv
// 32-bit Galois LFSR mask source, advanced LFSR_STEPS steps per enabled clock.
// Latency: load/advance visible on state the cycle after the strobe.
// Backpressure: none; the owner decides when to load or advance.
//
// Ports:
//   clk, rst     - clock and asynchronous active-high reset (state -> 32'h1)
//   load, seed   - load sanitised seed (zero replaced by 32'h1); wins over enable
//   enable       - advance LFSR_STEPS Galois steps this cycle
//   state        - current LFSR contents
module dom_lfsr32
    import dom_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        enable,
    input  logic [31:0] seed,
    output logic [31:0] state
);

    logic [31:0] state_q;
    logic [31:0] state_d;
    logic [31:0] state_adv;

    // Fully unrolled multi-step advance: LFSR_STEPS chained single steps,
    // which flattens into a shallow XOR network per output bit.
    always_comb begin
        state_adv = state_q;
        for (int i = 0; i < LFSR_STEPS; i++) begin
            state_adv = lfsr_step(state_adv);
        end
    end

    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = lfsr_seed_fix(seed);
        end else if (enable) begin
            state_d = state_adv;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= LFSR_NONZERO;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/dom_share_gen.sv
// Splits an unmasked operand pair (a, b) into three Boolean shares each and
// attaches three fresh refreshing bits for a downstream DOM AND stage.
// Latency 1 (registered output); holds output while out_ready is low,
// in_ready low until seeded and warmed up, full-throughput take+accept.
//
// Ports:
//   clk, rst              - clock, asynchronous active-high reset
//   seed_valid, seed      - PRNG seed strobe and value
//   in_valid/in_ready     - operand handshake, in_a/in_b operands
//   out_valid/out_ready   - share handshake
//   a_sh, b_sh            - shares of a and b (XOR of the three bits = operand)
//   refreshing            - fresh masks for the DOM AND stage
//
// Build option: define DOM_SHARE_GEN_RESEED_EN to allow seed_valid in WARMUP
// or RUN to reload the LFSR, drop any held output and restart the warmup.
// Without it, seed_valid is honoured only in UNSEEDED.
module dom_share_gen
    import dom_pkg::*;
#(
    parameter int WARMUP_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              seed_valid,
    input  logic [31:0]       seed,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_a,
    input  logic              in_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [SHARES-1:0] a_sh,
    output logic [SHARES-1:0] b_sh,
    output logic [SHARES-1:0] refreshing
);

    // Counter hits this value in the final warmup cycle.
    localparam logic [7:0] WARM_LAST = 8'(WARMUP_CYCLES - 1);

    dom_state_e  state_q;
    dom_state_e  state_d;
    logic [7:0]  warm_cnt_q;
    logic [7:0]  warm_cnt_d;
    logic        out_valid_q;
    logic        out_valid_d;
    share_dat_t  out_dat_q;
    share_dat_t  out_dat_d;

    logic        lfsr_load;
    logic        lfsr_en;
    logic [31:0] lfsr_state;
    logic [6:0]  r;
    logic        reseed;
    logic        accept;

    // ------------------------------------------------------------------
    // Mask source
    // ------------------------------------------------------------------
    dom_lfsr32 u_lfsr (
        .clk    (clk),
        .rst    (rst),
        .load   (lfsr_load),
        .enable (lfsr_en),
        .seed   (seed),
        .state  (lfsr_state)
    );

    // The masks are taken from the LFSR state of the accept cycle itself; the
    // LFSR advances on the same edge, so the next pair sees fresh bits.
    assign r = lfsr_state[6:0];

    // A runtime reseed only exists in the optional build; in the default
    // build seed_valid outside UNSEEDED has no effect at all.
`ifdef DOM_SHARE_GEN_RESEED_EN
    assign reseed = seed_valid & (state_q != ST_UNSEEDED);
`else
    assign reseed = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Seeding / warmup FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        warm_cnt_d = warm_cnt_q;
        lfsr_load  = 1'b0;
        lfsr_en    = 1'b0;

        unique case (state_q)
            ST_UNSEEDED: begin
                // LFSR is frozen until software provides entropy.
                if (seed_valid) begin
                    lfsr_load  = 1'b1;
                    warm_cnt_d = 8'd0;
                    state_d    = ST_WARMUP;
                end
            end
            ST_WARMUP: begin
                // Spin the LFSR so the first masks are far from the raw seed.
                lfsr_en = 1'b1;
                if (warm_cnt_q == WARM_LAST) begin
                    warm_cnt_d = 8'd0;
                    state_d    = ST_RUN;
                end else begin
                    warm_cnt_d = warm_cnt_q + 8'd1;
                end
            end
            ST_RUN: begin
                // Free-running: masks change every cycle whether or not a pair
                // is accepted, so consumption rate does not shape the stream.
                lfsr_en = 1'b1;
            end
            default: begin
                state_d    = ST_UNSEEDED;
                warm_cnt_d = 8'd0;
            end
        endcase

        // Reseed overrides everything: reload and start a full warmup again.
        if (reseed) begin
            lfsr_load  = 1'b1;
            lfsr_en    = 1'b0;
            warm_cnt_d = 8'd0;
            state_d    = ST_WARMUP;
        end
    end

    // ------------------------------------------------------------------
    // Handshake and share formation
    // ------------------------------------------------------------------
    // Ready only in RUN with a free (or freeing) output slot; a reseed cycle
    // never accepts, as the pair would be masked with soon-discarded bits.
    assign in_ready = (state_q == ST_RUN) & (~out_valid_q | out_ready) & ~reseed;
    assign accept   = in_valid & in_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        out_dat_d   = out_dat_q;

        if (accept) begin
            // Two random shares plus a third that restores the operand value;
            // a simultaneous take is covered because accept implies the slot
            // is free or being emptied this cycle.
            out_valid_d          = 1'b1;
            out_dat_d.a_sh       = {in_a ^ r[0] ^ r[1], r[1], r[0]};
            out_dat_d.b_sh       = {in_b ^ r[2] ^ r[3], r[3], r[2]};
            out_dat_d.refreshing = r[6:4];
        end else if (out_valid_q & out_ready) begin
            out_valid_d = 1'b0;
        end

        // Held shares were made from the old seed; do not let them escape.
        if (reseed) begin
            out_valid_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_UNSEEDED;
            warm_cnt_q  <= 8'd0;
            out_valid_q <= 1'b0;
            out_dat_q   <= '0;
        end else begin
            state_q     <= state_d;
            warm_cnt_q  <= warm_cnt_d;
            out_valid_q <= out_valid_d;
            out_dat_q   <= out_dat_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign a_sh       = out_dat_q.a_sh;
    assign b_sh       = out_dat_q.b_sh;
    assign refreshing = out_dat_q.refreshing;

endmodule

// File: tb/tb_dom_share_gen.sv
// Self-checking bench for dom_share_gen: reference model of the seeding FSM
// and LFSR, scoreboard queue of expected shares, and directed phases for
// unseeded idling, warmup timing, random traffic, stalls, reseed and reset.
`timescale 1ns/1ps
module tb_dom_share_gen;

    localparam int          WARM  = 16;
    localparam logic [31:0] MPOLY = 32'h8020_0003;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        seed_valid = 1'b0;
    logic [31:0] seed = 32'h0;
    logic        in_valid = 1'b0;
    logic        in_a = 1'b0;
    logic        in_b = 1'b0;
    logic        out_ready = 1'b0;
    logic        in_ready;
    logic        out_valid;
    logic [2:0]  a_sh;
    logic [2:0]  b_sh;
    logic [2:0]  refreshing;

    dom_share_gen #(.WARMUP_CYCLES(WARM)) dut (
        .clk        (clk),
        .rst        (rst),
        .seed_valid (seed_valid),
        .seed       (seed),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .a_sh       (a_sh),
        .b_sh       (b_sh),
        .refreshing (refreshing)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       ia;
        logic       ib;
        logic [2:0] a;
        logic [2:0] b;
        logic [2:0] r;
    } exp_t;

    exp_t       sb[$];
    logic [8:0] stream[$];
    logic [8:0] s1[$];
    int n_chk  = 0;
    int n_err  = 0;
    int n_push = 0;
    int n_pop  = 0;
    int n_drop = 0;
    bit rec_en = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int          m_st   = 0;      // 0 unseeded, 1 warmup, 2 run
    logic [31:0] m_lfsr = 32'h1;
    int          m_cnt  = 0;
    bit          m_ov   = 1'b0;

    function automatic logic [31:0] adv8(input logic [31:0] s);
        logic [31:0] t;
        t = s;
        for (int i = 0; i < 8; i++) begin
            if (t[0]) t = (t >> 1) ^ MPOLY;
            else      t = t >> 1;
        end
        return t;
    endfunction

    function automatic bit reseed_now();
`ifdef DOM_SHARE_GEN_RESEED_EN
        return seed_valid && (m_st != 0);
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit exp_rdy();
        return (m_st == 2) && (!m_ov || out_ready) && !reseed_now();
    endfunction

    always @(posedge clk or posedge rst) begin
        bit   acc;
        bit   rs;
        exp_t e;
        if (rst) begin
            m_st = 0; m_lfsr = 32'h1; m_cnt = 0; m_ov = 1'b0;
            n_drop += sb.size();
            sb.delete();
        end else begin
            acc = in_valid && exp_rdy();
            rs  = reseed_now();
            if (acc) begin
                e.ia = in_a;
                e.ib = in_b;
                e.a  = {in_a ^ m_lfsr[0] ^ m_lfsr[1], m_lfsr[1], m_lfsr[0]};
                e.b  = {in_b ^ m_lfsr[2] ^ m_lfsr[3], m_lfsr[3], m_lfsr[2]};
                e.r  = m_lfsr[6:4];
                sb.push_back(e);
                n_push++;
                m_ov = 1'b1;
            end else if (m_ov && out_ready) begin
                m_ov = 1'b0;
            end
            if (rs) begin
                m_ov = 1'b0;
                n_drop += sb.size();
                sb.delete();
                m_lfsr = (seed == 0) ? 32'h1 : seed;
                m_cnt = 0; m_st = 1;
            end else begin
                case (m_st)
                    0: if (seed_valid) begin
                        m_lfsr = (seed == 0) ? 32'h1 : seed;
                        m_cnt = 0; m_st = 1;
                    end
                    1: begin
                        m_lfsr = adv8(m_lfsr);
                        if (m_cnt == WARM - 1) begin m_st = 2; m_cnt = 0; end
                        else m_cnt++;
                    end
                    default: m_lfsr = adv8(m_lfsr);
                endcase
            end
        end
    end

    // ---------------- checker (mid-cycle) ----------------
    always @(negedge clk) begin
        chk("in_ready", 32'(in_ready), 32'(exp_rdy()));
        chk("out_valid", 32'(out_valid), 32'(m_ov));
        if (m_ov && sb.size() > 0) begin
            chk("a_sh", 32'(a_sh), 32'(sb[0].a));
            chk("b_sh", 32'(b_sh), 32'(sb[0].b));
            chk("refreshing", 32'(refreshing), 32'(sb[0].r));
            chk("xor_a", 32'(^a_sh), 32'(sb[0].ia));
            chk("xor_b", 32'(^b_sh), 32'(sb[0].ib));
        end
        if (out_valid && out_ready && sb.size() > 0) begin
            if (rec_en) stream.push_back({a_sh, b_sh, refreshing});
            void'(sb.pop_front());
            n_pop++;
        end
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_stream(input logic [31:0] s);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        stream.delete();
        rec_en = 1'b1;
        seed = s; seed_valid = 1'b1;
        tick();
        seed_valid = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (WARM + 4) tick();
        for (int i = 0; i < 24; i++) begin
            in_valid = 1'b1;
            in_a = 1'((i / 2) % 2);
            in_b = 1'(((i * 5) / 3) % 2);
            tick();
        end
        in_valid = 1'b0;
        repeat (3) tick();
        rec_en = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed sequence ----------------
    initial begin
        logic [8:0] cap;
        int         target;
        int         budget;

        // Reset values
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_a_sh", 32'(a_sh), 32'd0);
        chk("rst_b_sh", 32'(b_sh), 32'd0);
        chk("rst_refreshing", 32'(refreshing), 32'd0);
        tick();
        rst = 1'b0;

        // Unseeded: offered traffic is never accepted
        in_valid = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 100; k++) begin
            in_a = 1'($urandom); in_b = 1'($urandom);
            tick();
            @(negedge clk);
            chk("unseeded_rdy", 32'(in_ready), 32'd0);
            chk("unseeded_ov", 32'(out_valid), 32'd0);
        end

        // Seed at cycle T, ready exactly at T+17
        in_valid = 1'b0;
        tick();
        seed = 32'h0000_0001; seed_valid = 1'b1;
        @(negedge clk);
        chk("seed_cycle_rdy", 32'(in_ready), 32'd0);
        for (int k = 1; k <= WARM; k++) begin
            tick();
            seed_valid = 1'b0;
            @(negedge clk);
            chk("warmup_rdy", 32'(in_ready), 32'd0);
        end
        tick();
        @(negedge clk);
        chk("run_rdy", 32'(in_ready), 32'd1);

        // Random traffic, random backpressure
        target = n_push + 1000;
        budget = 0;
        tick();
        in_valid = 1'b1;
        while (n_push < target && budget < 20000) begin
            in_a = 1'($urandom); in_b = 1'($urandom);
            out_ready = 1'($urandom_range(0, 1));
            tick();
            budget++;
        end
        chk("rand_budget", 32'(n_push >= target), 32'd1);
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        chk("drain_empty", 32'(sb.size()), 32'd0);
        chk("no_loss_dup", 32'(n_pop + n_drop), 32'(n_push));

        // Stall: output held stable for 10 cycles, then take+accept same cycle
        tick();
        in_valid = 1'b1; in_a = 1'b1; in_b = 1'b0; out_ready = 1'b0;
        tick();
        @(negedge clk);
        chk("stall_ov", 32'(out_valid), 32'd1);
        cap = {a_sh, b_sh, refreshing};
        for (int k = 0; k < 10; k++) begin
            tick();
            in_a = 1'(k); in_b = 1'(k + 1);
            @(negedge clk);
            chk("stall_stable", 32'({a_sh, b_sh, refreshing}), 32'(cap));
            chk("stall_rdy", 32'(in_ready), 32'd0);
        end
        tick();
        out_ready = 1'b1;
        @(negedge clk);
        chk("take_accept_rdy", 32'(in_ready), 32'd1);
        tick();
        @(negedge clk);
        chk("no_bubble_ov", 32'(out_valid), 32'd1);

        // seed_valid while RUN with a held output
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        tick();
        seed = $urandom; seed_valid = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
        @(negedge clk);
`ifdef DOM_SHARE_GEN_RESEED_EN
        chk("reseed_cycle_rdy", 32'(in_ready), 32'd0);
        tick();
        seed_valid = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        chk("reseed_drop_ov", 32'(out_valid), 32'd0);
        chk("reseed_warm_rdy", 32'(in_ready), 32'd0);
        for (int k = 2; k <= WARM; k++) begin
            tick();
            @(negedge clk);
            chk("reseed_warm_rdy", 32'(in_ready), 32'd0);
        end
        tick();
        @(negedge clk);
        chk("reseed_run_rdy", 32'(in_ready), 32'd1);
`else
        chk("ignored_seed_rdy", 32'(in_ready), 32'd1);
        tick();
        seed_valid = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        chk("ignored_seed_ov", 32'(out_valid), 32'd1);
`endif

        // Asynchronous reset with an output held
        tick();
        in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        chk("pre_rst_ov", 32'(out_valid), 32'd1);
        tick();
        rst = 1'b1;
        #1;
        chk("async_rst_ov", 32'(out_valid), 32'd0);
        chk("async_rst_rdy", 32'(in_ready), 32'd0);
        chk("async_rst_a_sh", 32'(a_sh), 32'd0);
        tick();
        rst = 1'b0;
        in_valid = 1'b1; out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            @(negedge clk);
            chk("post_rst_rdy", 32'(in_ready), 32'd0);
        end

        // seed 0 and seed 1 must give the same stream
        run_stream(32'h0000_0001);
        s1 = stream;
        chk("stream1_len", 32'(s1.size()), 32'd24);
        run_stream(32'h0000_0000);
        chk("stream0_len", 32'(stream.size()), 32'(s1.size()));
        for (int i = 0; i < s1.size() && i < stream.size(); i++) begin
            chk("seed0_vs_seed1", 32'(stream[i]), 32'(s1[i]));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
